// File: rtl/debug_inst_gen_pkg.sv
// Shared RISC-V encodings and debug command types for the debug instruction generator.
// Command opcodes, CSR addresses, register indices and the I-type word builder.
package riscv_types;

    typedef enum logic [2:0] {
        GPR_R = 3'd0,
        GPR_W = 3'd1,
        CSR_R = 3'd2,
        CSR_W = 3'd3,
        MEM_R = 3'd4
    } debug_cmd_t;

    typedef enum logic [11:0] {
        CSR_DSCRATCH = 12'h7B2,
        CSR_DDATA    = 12'h7C0
    } csr_reg_addr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_RESTORE,
        S_DONE
    } gen_state_t;

    localparam logic [4:0] REG_X0      = 5'd0;
    localparam logic [4:0] REG_S0      = 5'd8;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [2:0] RW_FN3      = 3'b001;
    localparam logic [2:0] RS_FN3      = 3'b010;
    localparam logic [2:0] LS_W_FN3    = 3'b010;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] fn3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, fn3, rd, opc};
    endfunction

    // s0 is parked in DSCRATCH around any sequence that clobbers it
    localparam logic [31:0] SAVE_WORD    = enc_i(CSR_DSCRATCH, REG_S0, RW_FN3, REG_X0, OPC_SYSTEM);
    localparam logic [31:0] RESTORE_WORD = enc_i(CSR_DSCRATCH, REG_X0, RS_FN3, REG_S0, OPC_SYSTEM);

    function automatic logic cmd_ok(input logic [2:0] op, input logic [11:0] regno);
        if (op == GPR_R || op == GPR_W) return regno[11:5] == 7'd0;
        return op inside {CSR_R, CSR_W, MEM_R};
    endfunction

endpackage

// File: rtl/debug_inst_gen_if.sv
// Command, instruction-injection and completion signals between a debug master and the generator.
// cmd_op carries the debug_cmd_t encoding as raw bits so undefined opcodes can be presented.
interface debug_inst_gen_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [11:0] cmd_regno;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        inst_retired;
    logic        inst_exception;
    logic        cmd_done;
    logic        cmd_error;

    modport master (
        output cmd_valid, cmd_op, cmd_regno, inst_ready, inst_retired, inst_exception,
        input  cmd_ready, inst_valid, inst, cmd_done, cmd_error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_regno, inst_ready, inst_retired, inst_exception,
        output cmd_ready, inst_valid, inst, cmd_done, cmd_error
    );
endinterface

// File: rtl/debug_inst_rom.sv
// Combinational table from (command, step, regno) to the RV32I word for that step.
// last marks the final step of the command's sequence.
module debug_inst_rom
    import riscv_types::*;
(
    input  logic [2:0]  op,
    input  logic [2:0]  step,
    input  logic [11:0] regno,
    output logic [31:0] word,
    output logic        last
);
    logic [31:0] rd_ddata_s0;
    logic [31:0] wr_ddata_s0;

    assign rd_ddata_s0 = enc_i(CSR_DDATA, REG_X0, RS_FN3, REG_S0, OPC_SYSTEM);
    assign wr_ddata_s0 = enc_i(CSR_DDATA, REG_S0, RW_FN3, REG_X0, OPC_SYSTEM);

    always_comb begin
        word = '0;
        last = 1'b1;
        case (op)
            GPR_R: word = enc_i(CSR_DDATA, regno[4:0], RW_FN3, REG_X0, OPC_SYSTEM);
            GPR_W: word = enc_i(CSR_DDATA, REG_X0, RS_FN3, regno[4:0], OPC_SYSTEM);
            CSR_R: begin
                last = (step == 3'd3);
                case (step)
                    3'd0:    word = SAVE_WORD;
                    3'd1:    word = enc_i(regno, REG_X0, RS_FN3, REG_S0, OPC_SYSTEM);
                    3'd2:    word = wr_ddata_s0;
                    default: word = RESTORE_WORD;
                endcase
            end
            CSR_W: begin
                last = (step == 3'd3);
                case (step)
                    3'd0:    word = SAVE_WORD;
                    3'd1:    word = rd_ddata_s0;
                    3'd2:    word = enc_i(regno, REG_S0, RW_FN3, REG_X0, OPC_SYSTEM);
                    default: word = RESTORE_WORD;
                endcase
            end
            MEM_R: begin
                last = (step == 3'd4);
                case (step)
                    3'd0:    word = SAVE_WORD;
                    3'd1:    word = rd_ddata_s0;
                    3'd2:    word = enc_i(12'h000, REG_S0, LS_W_FN3, REG_S0, OPC_LOAD);
                    3'd3:    word = wr_ddata_s0;
                    default: word = RESTORE_WORD;
                endcase
            end
            default: begin
                word = '0;
                last = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/debug_inst_gen.sv
// Debug instruction generator: turns debugger commands into injected RV32I sequences,
// tracks in-flight instructions and reports completion/error.
module debug_inst_gen
    import riscv_types::*;
(
    input  logic            clk,
    input  logic            rst,
    debug_inst_gen_if.slave bus
);
    gen_state_t  state;
    logic [2:0]  op_q;
    logic [11:0] regno_q;
    logic [2:0]  step_q;
    logic [2:0]  outst_q;
    logic [2:0]  outst_nxt;
    logic        err_q;
    logic        restore_hs_q;
    logic        cmd_ready_q;
    logic        inst_valid_q;
    logic        cmd_done_q;
    logic        cmd_error_q;
    logic [31:0] rom_word;
    logic        rom_last;
    logic        hs;
    logic        ret;
    logic        exc;
    logic        saved;

    debug_inst_rom u_rom (
        .op    (op_q),
        .step  (step_q),
        .regno (regno_q),
        .word  (rom_word),
        .last  (rom_last)
    );

    assign hs  = inst_valid_q && bus.inst_ready;
    // a trapping instruction still leaves the pipeline, so it retires like any other
    assign ret = (bus.inst_retired || bus.inst_exception)
                 && (state inside {S_ISSUE, S_DRAIN, S_RESTORE});
    assign exc = bus.inst_exception && (state inside {S_ISSUE, S_DRAIN});
    assign saved = (op_q inside {CSR_R, CSR_W, MEM_R}) && (step_q != 3'd0 || hs);

    always_comb begin
        outst_nxt = outst_q;
        if (hs && !ret)
            outst_nxt = outst_q + 3'd1;
        else if (!hs && ret && outst_q != 3'd0)
            outst_nxt = outst_q - 3'd1;
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = !inst_valid_q ? 32'h0 : (state == S_RESTORE) ? RESTORE_WORD : rom_word;
    assign bus.cmd_done   = cmd_done_q;
    assign bus.cmd_error  = cmd_error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= '0;
            regno_q      <= '0;
            step_q       <= '0;
            outst_q      <= '0;
            err_q        <= 1'b0;
            restore_hs_q <= 1'b0;
            cmd_ready_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            cmd_done_q   <= 1'b0;
            cmd_error_q  <= 1'b0;
        end else begin
            cmd_done_q  <= 1'b0;
            cmd_error_q <= 1'b0;
            outst_q     <= outst_nxt;
            case (state)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        op_q         <= bus.cmd_op;
                        regno_q      <= bus.cmd_regno;
                        step_q       <= '0;
                        outst_q      <= '0;
                        err_q        <= 1'b0;
                        restore_hs_q <= 1'b0;
                        cmd_ready_q  <= 1'b0;
                        if (cmd_ok(bus.cmd_op, bus.cmd_regno)) begin
                            state        <= S_ISSUE;
                            inst_valid_q <= 1'b1;
                        end else begin
                            state       <= S_DONE;
                            cmd_done_q  <= 1'b1;
                            cmd_error_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (hs) step_q <= step_q + 3'd1;
                    if (exc) begin
                        err_q        <= 1'b1;
                        state        <= saved ? S_RESTORE : S_DRAIN;
                        inst_valid_q <= saved;
                    end else if (hs && rom_last) begin
                        state        <= S_DRAIN;
                        inst_valid_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (exc) begin
                        err_q <= 1'b1;
                        if (saved) begin
                            state        <= S_RESTORE;
                            inst_valid_q <= 1'b1;
                        end
                    end else if (outst_q == 3'd0) begin
                        state       <= S_DONE;
                        cmd_done_q  <= 1'b1;
                        cmd_error_q <= err_q;
                    end
                end
                S_RESTORE: begin
                    if (hs) begin
                        inst_valid_q <= 1'b0;
                        restore_hs_q <= 1'b1;
                    end
                    if (restore_hs_q && outst_q == 3'd0) begin
                        state       <= S_DONE;
                        cmd_done_q  <= 1'b1;
                        cmd_error_q <= err_q;
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_inst_gen.sv
// Bench for debug_inst_gen: a small core model accepts/retires injected words and the
// captured stream is compared with the word list each command should produce.
module tb_debug_inst_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_inst_gen_if bus();
    debug_inst_gen dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pend_cyc[$];
    bit pend_trap[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bit exp_err;
    bit exp_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sys(input int csr, input int rs1, input int f3, input int rd);
        return (32'(csr) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h73;
    endfunction

    // Expected word list from the command definitions; a trap truncates the list
    // and, for s0-saving commands, appends the restore word.
    task automatic build_exp(input int op, input int regno, input int trap);
        logic [31:0] seq[$];
        logic [31:0] save;
        logic [31:0] rest;
        save = sys('h7B2, 8, 1, 0);
        rest = sys('h7B2, 0, 2, 8);
        seq.delete();
        exp_q.delete();
        exp_bad = 1'b0;
        case (op)
            0: if (regno < 32) seq.push_back(sys('h7C0, regno, 1, 0)); else exp_bad = 1'b1;
            1: if (regno < 32) seq.push_back(sys('h7C0, 0, 2, regno)); else exp_bad = 1'b1;
            2: begin
                seq.push_back(save); seq.push_back(sys(regno, 0, 2, 8));
                seq.push_back(sys('h7C0, 8, 1, 0)); seq.push_back(rest);
            end
            3: begin
                seq.push_back(save); seq.push_back(sys('h7C0, 0, 2, 8));
                seq.push_back(sys(regno, 8, 1, 0)); seq.push_back(rest);
            end
            4: begin
                seq.push_back(save); seq.push_back(sys('h7C0, 0, 2, 8));
                seq.push_back(32'((8 << 15) | (2 << 12) | (8 << 7) | 3));
                seq.push_back(sys('h7C0, 8, 1, 0)); seq.push_back(rest);
            end
            default: exp_bad = 1'b1;
        endcase
        exp_err = exp_bad;
        if (!exp_bad) begin
            if (trap < seq.size()) begin
                for (int i = 0; i <= trap; i++) exp_q.push_back(seq[i]);
                if (op >= 2) exp_q.push_back(rest);
                exp_err = 1'b1;
            end else begin
                exp_q = seq;
            end
        end
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.inst_ready = 1'b0;
        bus.inst_retired = 1'b0;
        bus.inst_exception = 1'b0;
    endtask

    task automatic run_cmd(input int op, input int regno, input int rdy_pct, input bit hold,
                           input int dmax, input int trap, input int rst_at, input string tag);
        bit acc_next = 1'b0, accepted = 1'b0, done = 1'b0, trapped = 1'b0, trap_pend = 1'b0;
        bit stall_prev = 1'b0, saw_valid = 1'b0, exc_now;
        int acc_cyc = 0, stall = 0, k = 0;
        logic [31:0] prev_inst = '0;
        build_exp(op, regno, trap);
        got_q.delete();
        @(negedge clk); cyc++;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'(op);
        bus.cmd_regno = 12'(regno);
        for (k = 0; k < 400 && !done; k++) begin
            if (stall_prev) begin
                chk({tag, " hold_word"}, bus.inst, prev_inst);
                chk({tag, " hold_valid"}, 32'(bus.inst_valid), 32'd1);
            end
            if (bus.inst_valid) saw_valid = 1'b1;
            if (bus.cmd_done) begin
                done = 1'b1;
                idle_inputs();
                chk({tag, " error"}, 32'(bus.cmd_error), 32'(exp_err));
                chk({tag, " ready_in_done"}, 32'(bus.cmd_ready), 32'd0);
                chk({tag, " n_words"}, got_q.size(), exp_q.size());
                for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                    chk($sformatf("%s word%0d", tag, i), got_q[i], exp_q[i]);
                chk({tag, " drained"}, pend_cyc.size(), 0);
                if (exp_bad) begin
                    chk({tag, " no_valid"}, 32'(saw_valid), 32'd0);
                    chk({tag, " latency"}, 32'((k - acc_cyc) inside {[1:2]}), 32'd1);
                end
                @(negedge clk); cyc++;
                chk({tag, " done_pulse"}, 32'(bus.cmd_done), 32'd0);
                chk({tag, " ready_after"}, 32'(bus.cmd_ready), 32'd1);
            end else if (rst_at >= 0 && got_q.size() == rst_at && bus.inst_valid) begin
                idle_inputs();
                rst = 1'b1;
                @(negedge clk); cyc++;
                chk({tag, " rst_valid"}, 32'(bus.inst_valid), 32'd0);
                chk({tag, " rst_inst"}, bus.inst, 32'd0);
                chk({tag, " rst_done"}, 32'(bus.cmd_done), 32'd0);
                chk({tag, " rst_ready"}, 32'(bus.cmd_ready), 32'd0);
                rst = 1'b0;
                @(negedge clk); cyc++;
                chk({tag, " rel_ready"}, 32'(bus.cmd_ready), 32'd1);
                chk({tag, " rel_valid"}, 32'(bus.inst_valid), 32'd0);
                return;
            end else begin
                if (acc_next) begin
                    bus.cmd_valid = 1'b0;
                    acc_next = 1'b0;
                    accepted = 1'b1;
                end else if (!accepted && bus.cmd_valid && bus.cmd_ready) begin
                    acc_next = 1'b1;
                    acc_cyc = k;
                end
                bus.inst_retired = 1'b0;
                bus.inst_exception = 1'b0;
                exc_now = 1'b0;
                if (pend_cyc.size() > 0 && cyc >= pend_cyc[0]) begin
                    if (pend_trap[0]) begin
                        bus.inst_exception = 1'b1;
                        exc_now = 1'b1;
                        trap_pend = 1'b0;
                    end else begin
                        bus.inst_retired = 1'b1;
                    end
                    void'(pend_cyc.pop_front());
                    void'(pend_trap.pop_front());
                end
                // the modelled core accepts nothing behind a trapping instruction
                if (exc_now || trap_pend) bus.inst_ready = 1'b0;
                else if (hold) bus.inst_ready = (stall >= 3);
                else bus.inst_ready = (int'($urandom_range(0, 99)) < rdy_pct);
                if (bus.inst_valid && bus.inst_ready) begin
                    got_q.push_back(bus.inst);
                    pend_cyc.push_back(cyc + int'($urandom_range(1, dmax)));
                    if (!trapped && got_q.size() - 1 == trap) begin
                        trapped = 1'b1;
                        trap_pend = 1'b1;
                        pend_trap.push_back(1'b1);
                    end else begin
                        pend_trap.push_back(1'b0);
                    end
                    stall = 0;
                end else if (bus.inst_valid) begin
                    stall++;
                end
                stall_prev = bus.inst_valid && !bus.inst_ready && !exc_now;
                prev_inst = bus.inst;
                @(negedge clk); cyc++;
            end
        end
        if (!done) begin
            chk({tag, " timeout"}, 32'(done), 32'd1);
            idle_inputs();
            rst = 1'b1;
            @(negedge clk); cyc++;
            rst = 1'b0;
            @(negedge clk); cyc++;
            pend_cyc.delete();
            pend_trap.delete();
        end
    endtask

    // Stray completion pulses while idle must not start or finish anything.
    task automatic idle_noise(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); cyc++;
            chk("idle_done", 32'(bus.cmd_done), 32'd0);
            chk("idle_valid", 32'(bus.inst_valid), 32'd0);
            bus.inst_retired = 1'($urandom_range(0, 1));
            bus.inst_exception = 1'($urandom_range(0, 1));
        end
        @(negedge clk); cyc++;
        bus.inst_retired = 1'b0;
        bus.inst_exception = 1'b0;
        pend_cyc.delete();
        pend_trap.delete();
    endtask

    initial begin
        int op, regno;
        rst = 1'b1;
        idle_inputs();
        bus.cmd_op = 3'd0;
        bus.cmd_regno = 12'd0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(bus.cmd_ready), 32'd0);
        chk("reset_valid", 32'(bus.inst_valid), 32'd0);
        chk("reset_inst", bus.inst, 32'd0);
        chk("reset_done", 32'(bus.cmd_done), 32'd0);
        chk("reset_error", 32'(bus.cmd_error), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_ready", 32'(bus.cmd_ready), 32'd1);

        run_cmd(0, 10, 100, 1'b0, 1, 99, -1, "gpr_r");
        run_cmd(1, 10, 100, 1'b0, 1, 99, -1, "gpr_w");
        run_cmd(2, 'h341, 100, 1'b1, 1, 99, -1, "csr_r_hold");
        run_cmd(4, 'h123, 100, 1'b0, 2, 2, -1, "mem_r_trap");
        run_cmd(0, 'h020, 100, 1'b0, 1, 99, -1, "gpr_r_bad");
        run_cmd(6, 0, 100, 1'b0, 1, 99, -1, "bad_op");
        run_cmd(3, 'h300, 100, 1'b0, 3, 99, 2, "csr_w_rst");
        idle_noise(6);
        run_cmd(3, 'h300, 70, 1'b0, 3, 99, -1, "csr_w");
        run_cmd(0, 5, 100, 1'b0, 1, 0, -1, "gpr_r_trap");
        run_cmd(2, 'hB00, 100, 1'b0, 1, 3, -1, "csr_r_trap_last");

        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 7));
            if (op < 2) regno = ($urandom_range(0, 3) == 0) ? int'($urandom_range(32, 4095))
                                                             : int'($urandom_range(0, 31));
            else regno = int'($urandom_range(0, 4095));
            run_cmd(op, regno, int'($urandom_range(30, 100)), 1'b0, 3,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : 99, -1,
                    $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
